rate_divider: RTL and testbench

- Converts the 50 MHz board clock into a slow, periodic one-cycle tick, `clk_out`.
- Downstream logic uses the rising edge of `clk_out` as its timebase. The display timer uses it to advance BCD digits once per second.
- Ticking is gated by a single enable input, driven from a board switch.
- Digit rendering is done by the separate hex_decoder block and is not part of this module.

---
 rtl/rate_divider_if.sv | 11 +
 rtl/rate_divider.sv | 43 ++++
 tb/tb_rate_divider.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/rate_divider_if.sv
`default_nettype none
// rate_divider_if: enable input and one-cycle tick output of rate_divider.
// Rev 1.0
interface rate_divider_if;
   logic enable;
   logic clk_out;

   modport master (output enable, input  clk_out);
   modport slave  (input  enable, output clk_out);
endinterface
`default_nettype wire

// File: rtl/rate_divider.sv
`default_nettype none
// rate_divider: divides CLOCK_50 into a one-cycle tick every DIVISOR enabled cycles.
// Rev 1.0
module rate_divider #(
   parameter int unsigned DIVISOR = 50000000
) (
   input  wire logic     CLOCK_50,
   input  wire logic     resetn,
   rate_divider_if.slave bus
);
   localparam int CNT_W = (DIVISOR < 2) ? 1 : $clog2(DIVISOR);
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DIVISOR - 1);

   // A divisor of 1 would hold the tick permanently high, leaving consumers no edge.
   generate
      if (DIVISOR < 2) begin : g_bad_divisor
         $error("rate_divider: DIVISOR must be at least 2");
      end
   endgenerate

   logic [CNT_W-1:0] cnt;
   logic             tick;

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         cnt  <= RELOAD;
         tick <= 1'b0;
      end else if (bus.enable) begin
         if (cnt == '0) begin
            cnt  <= RELOAD;
            tick <= 1'b1;
         end else begin
            cnt  <= cnt - 1'b1;
            tick <= 1'b0;
         end
      end else begin
         tick <= 1'b0;
      end
   end

   assign bus.clk_out = tick;
endmodule
`default_nettype wire

// File: tb/tb_rate_divider.sv
`default_nettype none
// tb_rate_divider: three divider instances (4, 5, 3) checked against an enabled-edge count model.
module tb_rate_divider;
   localparam int unsigned D0 = 4;
   localparam int unsigned D1 = 5;
   localparam int unsigned D2 = 3;

   int unsigned divs [3] = '{D0, D1, D2};

   logic       clk    = 1'b0;
   logic       resetn = 1'b0;
   logic [2:0] en     = 3'b000;
   logic [2:0] outs;

   int checks = 0;
   int fails  = 0;
   int ticks;
   int last;
   logic found;

   logic [2:0]  exp_q [$];
   int unsigned n [3];

   rate_divider_if bus0 ();
   rate_divider_if bus1 ();
   rate_divider_if bus2 ();

   assign bus0.enable = en[0];
   assign bus1.enable = en[1];
   assign bus2.enable = en[2];
   assign outs = {bus2.clk_out, bus1.clk_out, bus0.clk_out};

   rate_divider #(.DIVISOR(D0)) u0 (.CLOCK_50(clk), .resetn(resetn), .bus(bus0));
   rate_divider #(.DIVISOR(D1)) u1 (.CLOCK_50(clk), .resetn(resetn), .bus(bus1));
   rate_divider #(.DIVISOR(D2)) u2 (.CLOCK_50(clk), .resetn(resetn), .bus(bus2));

   always #10 clk = ~clk;

   // Reference: a tick is due on every enabled edge whose enabled-edge count since reset is a multiple of DIVISOR.
   always @(posedge clk) begin : model
      logic [2:0] e;
      e = 3'b000;
      for (int k = 0; k < 3; k++) begin
         if (!resetn) begin
            n[k] = 0;
         end else if (en[k]) begin
            n[k] = n[k] + 1;
            e[k] = ((n[k] % divs[k]) == 0);
         end
      end
      exp_q.push_back(e);
   end

   always @(negedge clk) begin : monitor
      logic [2:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (outs[k] !== (e[k] & resetn)) begin
               fails++;
               $display("FAIL clk_out_u%0d at %0t: got %b expected %b", k, $time, outs[k], e[k] & resetn);
            end
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic expect_int(input string name, input int got, input int want);
      checks++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, want);
      end
   endtask

   initial begin
      resetn = 1'b0;
      en     = 3'b000;
      repeat (3) step();
      expect_int("reset_out_u0", int'(outs[0]), 0);
      expect_int("reset_out_u1", int'(outs[1]), 0);
      expect_int("reset_out_u2", int'(outs[2]), 0);
      expect_int("reset_cnt_u0", int'(u0.cnt), 3);

      // Continuous run: D=4 ticks on edges 4,8,12...; D=3 gives 10 evenly spaced ticks in 30 edges.
      resetn = 1'b1;
      en     = 3'b111;
      ticks  = 0;
      last   = 0;
      for (int i = 1; i <= 30; i++) begin
         step();
         if (outs[2]) begin
            if (ticks > 0) expect_int("spacing_u2", i - last, 3);
            ticks++;
            last = i;
         end
      end
      expect_int("tick_count_u2", ticks, 10);

      // Enable gap on D=4: two enabled edges, five frozen, then resume.
      resetn = 1'b0;
      en     = 3'b000;
      repeat (2) step();
      resetn = 1'b1;
      en[0]  = 1'b1;
      repeat (2) step();
      en[0] = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         expect_int("gap_cnt_u0", int'(u0.cnt), 1);
      end
      en[0] = 1'b1;
      step();
      expect_int("resume_early_u0", int'(outs[0]), 0);
      step();
      expect_int("resume_tick_u0", int'(outs[0]), 1);

      // Drop enable while the tick is high.
      en[0] = 1'b0;
      step();
      expect_int("cut_tick_u0", int'(outs[0]), 0);
      expect_int("cut_cnt_u0", int'(u0.cnt), 3);
      en[0] = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         step();
         expect_int("after_cut_u0", int'(outs[0]), (i == 4) ? 1 : 0);
      end

      // Asynchronous reset on D=5 while its tick is high.
      en    = 3'b010;
      found = 1'b0;
      for (int i = 0; i < 12 && !found; i++) begin
         step();
         if (outs[1]) found = 1'b1;
      end
      expect_int("wait_tick_u1", int'(found), 1);
      #3;
      resetn = 1'b0;
      #1;
      expect_int("async_reset_u1", int'(outs[1]), 0);
      expect_int("async_cnt_u1", int'(u1.cnt), 4);
      repeat (2) step();
      resetn = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         step();
         expect_int("post_reset_u1", int'(outs[1]), (i == 5) ? 1 : 0);
      end

      // Random enables with occasional one-cycle resets.
      for (int i = 0; i < 400; i++) begin
         step();
         en     = 3'($urandom);
         resetn = ($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1;
      end
      resetn = 1'b1;
      repeat (3) step();

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
`default_nettype wire
